decode_queue: RTL and testbench

- Parametrised successor to the single-instruction combinational decoder.
- Buffers fetched RV32I instructions and their PCs in a DEPTH-entry FIFO.
- Decodes the head entry into instruction_t, plus illegal-instruction detection.
- Presents the result through a registered valid/ready output stage feeding the execute-side pipeline register.
- Sits between fetch and execute, decoupling fetch stalls from backend stalls; supports pipeline flush.

---
 rtl/decode_queue_if.sv | 66 ++++++
 rtl/decode_queue.sv | 193 +++++++++++++++++++
 tb/tb_decode_queue.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// Shared decode types and the fetch/execute handshake bundle for decode_queue.
// The package travels with the interface so that both sides see one definition
// of instruction_t.
package decode_queue_pkg;

    typedef enum logic [5:0] {
        NOP, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } instr_name_t;

    typedef struct packed {
        instr_name_t instr_name;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
    } instruction_t;

endpackage

interface decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 3
);
    import decode_queue_pkg::*;

    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_instr_i;
    logic [XLEN-1:0]  in_pc_i;
    logic             out_valid_o;
    logic             out_ready_i;
    instruction_t     out_instr_o;
    logic [XLEN-1:0]  out_pc_o;
    logic             out_illegal_o;
    logic [CNT_W-1:0] count_o;
    logic [31:0]      perf_decoded_o;
    logic [31:0]      perf_stall_o;

    // Fetch/execute side driving the queue
    modport master (
        output flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_illegal_o,
               count_o, perf_decoded_o, perf_stall_o
    );

    // The queue itself
    modport slave (
        input  flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_illegal_o,
               count_o, perf_decoded_o, perf_stall_o
    );

endinterface

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO between fetch and execute with an
// RV32I decoder in front of a registered valid/ready output stage.
// Optional macro DECODE_PERF_EN adds hand-off and back-pressure counters.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    decode_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][31:0]     mem_instr;
    logic [DEPTH-1:0][XLEN-1:0] mem_pc;
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count_q;

    logic                       out_valid_q;
    instruction_t               out_instr_q;
    logic [XLEN-1:0]            out_pc_q;
    logic                       out_ill_q;

    logic                       fifo_empty, in_ready, push, pop, stage_free;
    logic                       take_head, take_bypass, fifo_wr;
    logic [31:0]                src_instr;
    logic [XLEN-1:0]            src_pc;
    instruction_t               dec;
    logic                       dec_ill;

    // The output stage frees up on a pop; it pulls from the FIFO head first and
    // only bypasses the incoming word when the FIFO is empty, keeping order.
    assign fifo_empty  = (count_q == '0);
    assign in_ready    = (count_q < CNT_W'(DEPTH)) && !bus.flush_i;
    assign push        = bus.in_valid_i && in_ready;
    assign pop         = out_valid_q && bus.out_ready_i;
    assign stage_free  = !out_valid_q || bus.out_ready_i;
    assign take_head   = stage_free && !fifo_empty;
    assign take_bypass = stage_free && fifo_empty && push;
    assign fifo_wr     = push && !take_bypass;
    assign src_instr   = fifo_empty ? bus.in_instr_i : mem_instr[rd_ptr];
    assign src_pc      = fifo_empty ? bus.in_pc_i    : mem_pc[rd_ptr];

    // RV32I field extraction, immediates, mnemonic and legality of the source word
    always_comb begin
        dec         = '0;
        dec_ill     = 1'b0;
        dec.opcode  = src_instr[6:0];
        dec.rd      = src_instr[11:7];
        dec.funct3  = src_instr[14:12];
        dec.rs1     = src_instr[19:15];
        dec.rs2     = src_instr[24:20];
        dec.funct7  = src_instr[31:25];
        dec.imm_i   = {{20{src_instr[31]}}, src_instr[31:20]};
        dec.imm_s   = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
        dec.imm_b   = {{19{src_instr[31]}}, src_instr[31], src_instr[7],
                       src_instr[30:25], src_instr[11:8], 1'b0};
        dec.imm_u   = {src_instr[31:12], 12'b0};
        dec.imm_j   = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                       src_instr[20], src_instr[30:21], 1'b0};
        dec.instr_name = NOP;
        case (dec.opcode)
            7'h37: dec.instr_name = LUI;
            7'h17: dec.instr_name = AUIPC;
            7'h6f: dec.instr_name = JAL;
            7'h67: if (dec.funct3 == 3'd0) dec.instr_name = JALR; else dec_ill = 1'b1;
            7'h63: case (dec.funct3)
                3'd0: dec.instr_name = BEQ;   3'd1: dec.instr_name = BNE;
                3'd4: dec.instr_name = BLT;   3'd5: dec.instr_name = BGE;
                3'd6: dec.instr_name = BLTU;  3'd7: dec.instr_name = BGEU;
                default: dec_ill = 1'b1;
            endcase
            7'h03: case (dec.funct3)
                3'd0: dec.instr_name = LB;    3'd1: dec.instr_name = LH;
                3'd2: dec.instr_name = LW;    3'd4: dec.instr_name = LBU;
                3'd5: dec.instr_name = LHU;
                default: dec_ill = 1'b1;
            endcase
            7'h23: case (dec.funct3)
                3'd0: dec.instr_name = SB;    3'd1: dec.instr_name = SH;
                3'd2: dec.instr_name = SW;
                default: dec_ill = 1'b1;
            endcase
            7'h13: case (dec.funct3)
                3'd0: dec.instr_name = ADDI;  3'd2: dec.instr_name = SLTI;
                3'd3: dec.instr_name = SLTIU; 3'd4: dec.instr_name = XORI;
                3'd6: dec.instr_name = ORI;   3'd7: dec.instr_name = ANDI;
                3'd1: if (dec.funct7 == 7'h00) dec.instr_name = SLLI; else dec_ill = 1'b1;
                default: begin
                    if (dec.funct7 == 7'h00)      dec.instr_name = SRLI;
                    else if (dec.funct7 == 7'h20) dec.instr_name = SRAI;
                    else                          dec_ill = 1'b1;
                end
            endcase
            7'h33: begin
                if (dec.funct7 == 7'h00) begin
                    case (dec.funct3)
                        3'd0: dec.instr_name = ADD;  3'd1: dec.instr_name = SLL;
                        3'd2: dec.instr_name = SLT;  3'd3: dec.instr_name = SLTU;
                        3'd4: dec.instr_name = XOR;  3'd5: dec.instr_name = SRL;
                        3'd6: dec.instr_name = OR;   default: dec.instr_name = AND;
                    endcase
                end else if (dec.funct7 == 7'h20 && dec.funct3 == 3'd0) begin
                    dec.instr_name = SUB;
                end else if (dec.funct7 == 7'h20 && dec.funct3 == 3'd5) begin
                    dec.instr_name = SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
        // A malformed sub-encoding carries no mnemonic
        if (dec_ill) dec.instr_name = NOP;
    end

    // FIFO storage; bypassed words never get written
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_instr[wr_ptr] <= bus.in_instr_i;
            mem_pc[wr_ptr]    <= bus.in_pc_i;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (fifo_wr)   wr_ptr <= wr_ptr + 1'b1;
            if (take_head) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CNT_W'(fifo_wr) - CNT_W'(take_head);
        end
    end

    // Registered output stage; contents hold while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_ill_q   <= 1'b0;
        end else if (bus.flush_i) begin
            out_valid_q <= 1'b0;
        end else if (stage_free) begin
            out_valid_q <= take_head || take_bypass;
            if (take_head || take_bypass) begin
                out_instr_q <= dec;
                out_pc_q    <= src_pc;
                out_ill_q   <= dec_ill;
            end
        end
    end

`ifdef DECODE_PERF_EN
    logic [31:0] perf_dec_q, perf_stall_q;

    // Hand-off and back-pressure counters; only reset clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dec_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pop)                              perf_dec_q   <= perf_dec_q + 1'b1;
            if (out_valid_q && !bus.out_ready_i) perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign bus.perf_decoded_o = perf_dec_q;
    assign bus.perf_stall_o   = perf_stall_q;
`else
    assign bus.perf_decoded_o = 32'd0;
    assign bus.perf_stall_o   = 32'd0;
`endif

    assign bus.in_ready_o    = in_ready;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.out_instr_o   = out_instr_q;
    assign bus.out_pc_o      = out_pc_q;
    assign bus.out_illegal_o = out_ill_q;
    assign bus.count_o       = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed decode vectors, multi-cycle corner
// sequences, then random traffic against a queue-based reference model.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;

    decode_queue_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct { logic [31:0] mask; logic [31:0] match; instr_name_t nm; } pat_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] instr; instr_name_t nm; logic ill; logic [4:0] rd; logic [31:0] imm; } vec_t;

    pat_t pats[$];
    vec_t vecs[$];
    ent_t mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference decode: an instruction is legal iff it matches one RV32I mask/match pattern
    function automatic void ref_dec(input logic [31:0] w, output instr_name_t n, output logic ill);
        n   = NOP;
        ill = 1'b1;
        foreach (pats[i]) if ((w & pats[i].mask) == pats[i].match) begin
            n   = pats[i].nm;
            ill = 1'b0;
        end
    endfunction

    task automatic check_entry(input string tag, input ent_t e);
        instr_name_t n;
        logic        ill;
        logic [31:0] w;
        w = e.instr;
        ref_dec(w, n, ill);
        chk({tag, ".valid"}, 32'(bus.out_valid_o), 32'd1);
        chk({tag, ".name"},  32'(bus.out_instr_o.instr_name), 32'(n));
        chk({tag, ".ill"},   32'(bus.out_illegal_o), 32'(ill));
        chk({tag, ".pc"},    bus.out_pc_o, e.pc);
        chk({tag, ".rd"},    32'(bus.out_instr_o.rd), 32'(w[11:7]));
        chk({tag, ".imm_i"}, bus.out_instr_o.imm_i, 32'($signed(w) >>> 20));
        chk({tag, ".imm_b"}, bus.out_instr_o.imm_b,
            {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0});
        chk({tag, ".imm_j"}, bus.out_instr_o.imm_j,
            {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0});
    endtask

    task automatic check_perf(input string tag, input int dec_n, input int stall_n);
`ifdef DECODE_PERF_EN
        chk({tag, ".perf_dec"},   bus.perf_decoded_o, 32'(dec_n));
        chk({tag, ".perf_stall"}, bus.perf_stall_o,   32'(stall_n));
`else
        chk({tag, ".perf_dec"},   bus.perf_decoded_o, 32'(dec_n - dec_n));
        chk({tag, ".perf_stall"}, bus.perf_stall_o,   32'(stall_n - stall_n));
`endif
    endtask

    task automatic idle();
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_instr_i  = '0;
        bus.in_pc_i     = '0;
        bus.out_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = w;
        bus.in_pc_i    = pc;
    endtask

    function automatic logic [31:0] addi(input int k);
        return (32'(k) << 20) | (32'(k & 31) << 7) | 32'h13;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        logic [6:0]  ops [9];
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            w[6:0] = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        idle();

        pats.push_back('{32'h7f, 32'h37, LUI});  pats.push_back('{32'h7f, 32'h17, AUIPC});
        pats.push_back('{32'h7f, 32'h6f, JAL});  pats.push_back('{32'h707f, 32'h67, JALR});
        pats.push_back('{32'h707f, 32'h0063, BEQ});  pats.push_back('{32'h707f, 32'h1063, BNE});
        pats.push_back('{32'h707f, 32'h4063, BLT});  pats.push_back('{32'h707f, 32'h5063, BGE});
        pats.push_back('{32'h707f, 32'h6063, BLTU}); pats.push_back('{32'h707f, 32'h7063, BGEU});
        pats.push_back('{32'h707f, 32'h0003, LB});   pats.push_back('{32'h707f, 32'h1003, LH});
        pats.push_back('{32'h707f, 32'h2003, LW});   pats.push_back('{32'h707f, 32'h4003, LBU});
        pats.push_back('{32'h707f, 32'h5003, LHU});
        pats.push_back('{32'h707f, 32'h0023, SB});   pats.push_back('{32'h707f, 32'h1023, SH});
        pats.push_back('{32'h707f, 32'h2023, SW});
        pats.push_back('{32'h707f, 32'h0013, ADDI}); pats.push_back('{32'h707f, 32'h2013, SLTI});
        pats.push_back('{32'h707f, 32'h3013, SLTIU}); pats.push_back('{32'h707f, 32'h4013, XORI});
        pats.push_back('{32'h707f, 32'h6013, ORI});  pats.push_back('{32'h707f, 32'h7013, ANDI});
        pats.push_back('{32'hfe00707f, 32'h1013, SLLI});
        pats.push_back('{32'hfe00707f, 32'h5013, SRLI});
        pats.push_back('{32'hfe00707f, 32'h40005013, SRAI});
        pats.push_back('{32'hfe00707f, 32'h0033, ADD}); pats.push_back('{32'hfe00707f, 32'h40000033, SUB});
        pats.push_back('{32'hfe00707f, 32'h1033, SLL}); pats.push_back('{32'hfe00707f, 32'h2033, SLT});
        pats.push_back('{32'hfe00707f, 32'h3033, SLTU}); pats.push_back('{32'hfe00707f, 32'h4033, XOR});
        pats.push_back('{32'hfe00707f, 32'h5033, SRL}); pats.push_back('{32'hfe00707f, 32'h40005033, SRA});
        pats.push_back('{32'hfe00707f, 32'h6033, OR});  pats.push_back('{32'hfe00707f, 32'h7033, AND});

        vecs.push_back('{32'h00500093, ADDI, 1'b0, 5'd1, 32'h5});
        vecs.push_back('{32'hFFF00113, ADDI, 1'b0, 5'd2, 32'hFFFFFFFF});
        vecs.push_back('{32'h0000B003, NOP,  1'b1, 5'd0, 32'h0});
        vecs.push_back('{32'h40001033, NOP,  1'b1, 5'd0, 32'h400});
        vecs.push_back('{32'h40005093, SRAI, 1'b0, 5'd1, 32'h400});
        vecs.push_back('{32'h00002083, LW,   1'b0, 5'd1, 32'h0});
        vecs.push_back('{32'h00001067, NOP,  1'b1, 5'd0, 32'h0});
        vecs.push_back('{32'h0000006F, JAL,  1'b0, 5'd0, 32'h0});
        vecs.push_back('{32'h123450B7, LUI,  1'b0, 5'd1, 32'h123});
        vecs.push_back('{32'h02000033, NOP,  1'b1, 5'd0, 32'h20});
        vecs.push_back('{32'h00000000, NOP,  1'b1, 5'd0, 32'h0});
        vecs.push_back('{32'h40000033, SUB,  1'b0, 5'd0, 32'h400});

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst.count", 32'(bus.count_o), 32'd0);
        chk("rst.pc",    bus.out_pc_o, 32'd0);
        chk("rst.ill",   32'(bus.out_illegal_o), 32'd0);
        chk("rst.name",  32'(bus.out_instr_o.instr_name), 32'(NOP));
        chk("rst.imm_i", bus.out_instr_o.imm_i, 32'd0);
        check_perf("rst", 0, 0);
        rst = 1'b0;

        // Decode table: each word bypasses into the stage and appears one cycle later
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            push_word(vecs[i].instr, 32'h100 + 32'(i * 4));
            @(negedge clk);
            chk($sformatf("vec%0d.valid", i), 32'(bus.out_valid_o), 32'd1);
            chk($sformatf("vec%0d.count", i), 32'(bus.count_o), 32'd0);
            chk($sformatf("vec%0d.name", i),  32'(bus.out_instr_o.instr_name), 32'(vecs[i].nm));
            chk($sformatf("vec%0d.ill", i),   32'(bus.out_illegal_o), 32'(vecs[i].ill));
            chk($sformatf("vec%0d.rd", i),    32'(bus.out_instr_o.rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d.imm_i", i), bus.out_instr_o.imm_i, vecs[i].imm);
            chk($sformatf("vec%0d.pc", i),    bus.out_pc_o, 32'h100 + 32'(i * 4));
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("vec.drained", 32'(bus.out_valid_o), 32'd0);

        // Fill under back-pressure: first word in the stage, four queued, then full
        do_reset();
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fill%0d.in_ready", k), 32'(bus.in_ready_o), 32'd1);
            push_word(addi(k + 1), 32'h200 + 32'(k * 4));
            @(negedge clk);
        end
        push_word(addi(6), 32'h214);
        for (int h = 0; h < 3; h++) begin
            chk($sformatf("full%0d.in_ready", h), 32'(bus.in_ready_o), 32'd0);
            chk($sformatf("full%0d.count", h),    32'(bus.count_o), 32'd4);
            check_entry($sformatf("full%0d", h), '{addi(1), 32'h200});
            @(negedge clk);
        end
        // four stalls while filling plus three while holding
        check_perf("stall", 0, 7);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check_entry($sformatf("drain%0d", k), '{addi(k + 1), 32'h200 + 32'(k * 4)});
            chk($sformatf("drain%0d.count", k), 32'(bus.count_o), 32'(4 - k));
        end
        @(negedge clk);
        chk("drain.empty", 32'(bus.out_valid_o), 32'd0);
        check_perf("drain", 5, 7);

        // Steady push+pop with two queued: count constant, pointers wrap
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_word(addi(k), 32'h300 + 32'(k * 4));
            @(negedge clk);
        end
        bus.out_ready_i = 1'b1;
        for (int j = 0; j < 10; j++) begin
            push_word(addi(j + 3), 32'h300 + 32'((j + 3) * 4));
            @(negedge clk);
            chk($sformatf("steady%0d.count", j), 32'(bus.count_o), 32'd2);
            check_entry($sformatf("steady%0d", j), '{addi(j + 1), 32'h300 + 32'((j + 1) * 4)});
        end
        bus.in_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("steady.empty", 32'(bus.out_valid_o), 32'd0);

        // Flush with a full queue and a simultaneous offer
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_word(addi(k), 32'h400 + 32'(k * 4));
            @(negedge clk);
        end
        bus.flush_i = 1'b1;
        push_word(32'h00000013, 32'hDEAD0);
        #1;
        chk("flush.in_ready", 32'(bus.in_ready_o), 32'd0);
        @(negedge clk);
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("flush.valid", 32'(bus.out_valid_o), 32'd0);
        chk("flush.count", 32'(bus.count_o), 32'd0);
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk("flush.dropped", 32'(bus.out_valid_o), 32'd0);

        // Asynchronous reset with three entries queued
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_word(addi(k + 7), 32'h500 + 32'(k * 4));
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        chk("pre_rst.count", 32'(bus.count_o), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", 32'(bus.out_valid_o), 32'd0);
        chk("arst.count", 32'(bus.count_o), 32'd0);
        chk("arst.name",  32'(bus.out_instr_o.instr_name), 32'(NOP));
        check_perf("arst", 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model: the stage plus FIFO behave as one
        // ordered queue of DEPTH+1 slots whose head is the visible output.
        begin
            int  m_dec, m_stall;
            logic exp_rdy, do_push, do_pop;
            m_dec   = 0;
            m_stall = 0;
            mq.delete();
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                chk("rnd.valid", 32'(bus.out_valid_o), 32'(mq.size() > 0));
                chk("rnd.count", 32'(bus.count_o), 32'(mq.size() > 0 ? mq.size() - 1 : 0));
                if (mq.size() > 0) check_entry("rnd", mq[0]);
                check_perf("rnd", m_dec, m_stall);
                bus.flush_i     = ($urandom_range(0, 31) == 0);
                bus.in_valid_i  = ($urandom_range(0, 3) != 0);
                bus.out_ready_i = ($urandom_range(0, 2) != 0);
                bus.in_instr_i  = rnd_instr();
                bus.in_pc_i     = $urandom & 32'hFFFFFFFC;
                #1;
                exp_rdy = (mq.size() <= DEPTH) && !bus.flush_i;
                chk("rnd.in_ready", 32'(bus.in_ready_o), 32'(exp_rdy));
                do_push = bus.in_valid_i && exp_rdy;
                do_pop  = (mq.size() > 0) && bus.out_ready_i;
                if (do_pop) m_dec++;
                if (mq.size() > 0 && !bus.out_ready_i) m_stall++;
                if (bus.flush_i) mq.delete();
                else begin
                    if (do_pop)  void'(mq.pop_front());
                    if (do_push) mq.push_back('{bus.in_instr_i, bus.in_pc_i});
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
